// File: rtl/button_event_decoder.sv
// Button gesture classifier: turns a debounced level into one-cycle
// short / double / long / repeat pulses plus a long-hold level.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   in       in   debounced button level (1 = pressed)
//   en       in   enable; 0 forces IDLE and silences all outputs
//   short_p  out  single short press confirmed (one cycle)
//   double_p out  second press released (one cycle)
//   long_p   out  press exceeded LONG_CYC (one cycle)
//   repeat_p out  every REPEAT_CYC while long-held (one cycle)
//   held     out  high while in the long-hold state
module button_event_decoder #(
    parameter int CNT_W      = 25,
    parameter int LONG_CYC   = 25_000_000,
    parameter int DBL_CYC    = 12_500_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic en,
    output logic short_p,
    output logic double_p,
    output logic long_p,
    output logic repeat_p,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_T  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_d_q;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    logic rise, fall;

    assign rise = in & ~in_d_q;
    assign fall = ~in & in_d_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                // A release on the terminal cycle still counts as short.
                if (fall) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_T) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                // A second press on the terminal cycle still counts as double.
                if (rise) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_T) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (cnt_q == REP_T) begin
                    repeat_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter only runs in timed states, so it can never wrap.
        if (state_d != state_q || repeat_d) begin
            cnt_d = '0;
        end else if (state_q == PRESS1 || state_q == WAIT2 ||
                     state_q == LONG) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            short_d  = 1'b0;
            double_d = 1'b0;
            long_d   = 1'b0;
            repeat_d = 1'b0;
        end

        held_d = (state_d == LONG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            // Treat the line as already high so a held button is ignored.
            in_d_q   <= 1'b1;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_d_q   <= in;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign short_p  = short_q;
    assign double_p = double_q;
    assign long_p   = long_q;
    assign repeat_p = repeat_q;
    assign held     = held_q;

endmodule
